// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port data-memory arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DFLT = 32;
  localparam int DATA_W_DFLT = 32;

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_LDR = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester, memory and status signals of the arbiter, bundled as one interface.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DFLT,
  parameter int DATA_W = DATA_W_DFLT
);
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              gnt0;
  logic              rvalid0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              gnt1;
  logic              rvalid1;

  logic [DATA_W-1:0] rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              owner;

  // Arbiter side.
  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  mem_rdata,
    output gnt0, rvalid0, gnt1, rvalid1, rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output owner
  );

  // Requesters plus memory.
  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output mem_rdata,
    input  gnt0, rvalid0, gnt1, rvalid1, rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  owner
  );
endinterface

// File: rtl/mem_port_arbiter_pick.sv
// Combinational winner select: round-robin with a bounded burst under contention.
module arb_pick_2
  import mem_arb_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 3
) (
  input  logic             req0,
  input  logic             req1,
  input  owner_e           last_owner,
  input  logic [CNT_W-1:0] burst_cnt,
  output logic             gnt_any,
  output owner_e           winner
);

  always_comb begin
    gnt_any = req0 | req1;
    winner  = OWNER_CPU;
    if (req0 && req1) begin
      // A zero count means the previous burst ended, so the other side goes first.
      if ((burst_cnt != '0) && (burst_cnt < CNT_W'(MAX_BURST)))
        winner = last_owner;
      else
        winner = owner_e'(~last_owner);
    end else if (req1) begin
      winner = OWNER_LDR;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read memory between the CPU data port and the loader,
// one access per cycle, read data returned to the granted port a cycle later.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DFLT,
  parameter int DATA_W    = DATA_W_DFLT,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus
);

  localparam int               CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  owner_e            last_owner;
  logic [CNT_W-1:0]  burst_cnt;
  logic              rd_vld0_p1;
  logic              rd_vld1_p1;

  logic              pick_any;
  owner_e            winner;
  logic              gnt0;
  logic              gnt1;
  logic              we_sel;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (cnt >= CNT_MAX) ? CNT_MAX : cnt + CNT_W'(1);
  endfunction

  arb_pick_2 #(
    .MAX_BURST (MAX_BURST),
    .CNT_W     (CNT_W)
  ) u_pick (
    .req0       (bus.req0),
    .req1       (bus.req1),
    .last_owner (last_owner),
    .burst_cnt  (burst_cnt),
    .gnt_any    (pick_any),
    .winner     (winner)
  );

  // p0: grant and memory request in the same cycle as the request
  assign gnt0 = pick_any & ~reset & (winner == OWNER_CPU);
  assign gnt1 = pick_any & ~reset & (winner == OWNER_LDR);

  always_comb begin
    addr_sel  = bus.addr0;
    wdata_sel = bus.wdata0;
    we_sel    = 1'b0;
    if (gnt1) begin
      addr_sel  = bus.addr1;
      wdata_sel = bus.wdata1;
      we_sel    = bus.we1;
    end else if (gnt0) begin
      we_sel    = bus.we0;
    end
  end

  assign bus.gnt0      = gnt0;
  assign bus.gnt1      = gnt1;
  assign bus.mem_en    = gnt0 | gnt1;
  assign bus.mem_we    = we_sel;
  assign bus.mem_addr  = addr_sel;
  assign bus.mem_wdata = wdata_sel;
  assign bus.owner     = last_owner;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_owner <= OWNER_LDR;
      burst_cnt  <= '0;
      rd_vld0_p1 <= 1'b0;
      rd_vld1_p1 <= 1'b0;
    end else begin
      rd_vld0_p1 <= gnt0 & ~bus.we0;
      rd_vld1_p1 <= gnt1 & ~bus.we1;
      if (gnt0 | gnt1) begin
        if (winner == last_owner) begin
          burst_cnt <= sat_inc(burst_cnt);
        end else begin
          last_owner <= winner;
          burst_cnt  <= CNT_W'(1);
        end
      end else begin
        burst_cnt <= '0;
      end
    end
  end

  // p1: read return, killed by reset so an in-flight read is dropped
  assign bus.rvalid0 = rd_vld0_p1 & ~reset;
  assign bus.rvalid1 = rd_vld1_p1 & ~reset;
  assign bus.rdata   = bus.mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table with explicit grants, a read-data
// scoreboard against a reference memory image, and a free-running contention run.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int MAX_BURST = 4;
  localparam logic [1:0] NA = 2'd2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bif();

  mem_port_arbiter #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];

  always @(posedge clk) begin
    if (bif.mem_en && bif.mem_we)  mem[bif.mem_addr[7:0]] <= bif.mem_wdata;
    if (bif.mem_en && !bif.mem_we) bif.mem_rdata <= mem[bif.mem_addr[7:0]];
  end

  typedef struct {
    logic        rst;
    logic        r0;
    logic        w0;
    logic [7:0]  a0;
    logic [31:0] d0;
    logic        r1;
    logic        w1;
    logic [7:0]  a1;
    logic [31:0] d1;
    logic        g0;
    logic        g1;
    logic [1:0]  own;
  } vec_t;

  typedef struct {
    logic        port;
    logic [31:0] data;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  logic exp_rv0 = 1'b0;
  logic exp_rv1 = 1'b0;
  int   run_len = 0;
  logic run_owner = 1'b0;
  int   cnt_g0 = 0;
  int   cnt_g1 = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input bit chk_gnt, input int idx);
    logic        g0, g1, ewe;
    logic [31:0] ea, ed;
    exp_t        e;
    @(negedge clk);
    reset      = v.rst;
    bif.req0   = v.r0;
    bif.we0    = v.w0;
    bif.addr0  = {24'd0, v.a0};
    bif.wdata0 = v.d0;
    bif.req1   = v.r1;
    bif.we1    = v.w1;
    bif.addr1  = {24'd0, v.a1};
    bif.wdata1 = v.d1;
    #1;
    if (chk_gnt) begin
      g0 = v.g0;
      g1 = v.g1;
      check($sformatf("gnt0@%0d", idx), bif.gnt0, g0);
      check($sformatf("gnt1@%0d", idx), bif.gnt1, g1);
    end else begin
      g0 = bif.gnt0;
      g1 = bif.gnt1;
      check($sformatf("gnt_onehot@%0d", idx), g0 ^ g1, 1'b1);
      if ((g1 == run_owner) && (run_len > 0)) run_len++;
      else begin
        run_owner = g1;
        run_len   = 1;
      end
      check($sformatf("burst_le_max@%0d", idx), run_len <= MAX_BURST, 1'b1);
      if (g0) cnt_g0++;
      if (g1) cnt_g1++;
    end
    ewe = g1 ? v.w1 : (g0 ? v.w0 : 1'b0);
    ea  = g1 ? {24'd0, v.a1} : {24'd0, v.a0};
    ed  = g1 ? v.d1 : v.d0;
    check($sformatf("mem_en@%0d", idx), bif.mem_en, g0 | g1);
    check($sformatf("mem_we@%0d", idx), bif.mem_we, ewe);
    check($sformatf("mem_addr@%0d", idx), bif.mem_addr, ea);
    check($sformatf("mem_wdata@%0d", idx), bif.mem_wdata, ed);
    if (v.own != NA) check($sformatf("owner@%0d", idx), bif.owner, v.own[0]);

    if (v.rst) begin
      check($sformatf("rvalid0_rst@%0d", idx), bif.rvalid0, 1'b0);
      check($sformatf("rvalid1_rst@%0d", idx), bif.rvalid1, 1'b0);
    end else begin
      check($sformatf("rvalid0@%0d", idx), bif.rvalid0, exp_rv0);
      check($sformatf("rvalid1@%0d", idx), bif.rvalid1, exp_rv1);
      if (exp_rv0 || exp_rv1) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL scoreboard@%0d: got empty queue, expected a pending read", idx);
        end else begin
          e = sb.pop_front();
          check($sformatf("rd_port@%0d", idx), exp_rv1, e.port);
          check($sformatf("rdata@%0d", idx), bif.rdata, e.data);
        end
      end
    end

    if (v.rst) begin
      sb.delete();
      exp_rv0 = 1'b0;
      exp_rv1 = 1'b0;
    end else begin
      exp_rv0 = g0 & ~v.w0;
      exp_rv1 = g1 & ~v.w1;
      if (g0 && !v.w0) sb.push_back('{port: 1'b0, data: ref_mem[v.a0]});
      if (g1 && !v.w1) sb.push_back('{port: 1'b1, data: ref_mem[v.a1]});
      if (g0 && v.w0)  ref_mem[v.a0] = v.d0;
      if (g1 && v.w1)  ref_mem[v.a1] = v.d1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    bif.req0 = 1'b0; bif.we0 = 1'b0; bif.addr0 = '0; bif.wdata0 = '0;
    bif.req1 = 1'b0; bif.we1 = 1'b0; bif.addr1 = '0; bif.wdata1 = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 32'hA500_0000 | i;
      ref_mem[i] = 32'hA500_0000 | i;
    end
    mem[8'h10]     = 32'hDEADBEEF;
    ref_mem[8'h10] = 32'hDEADBEEF;

    //            rst r0 w0 a0     d0            r1 w1 a1     d1            g0 g1 own
    tbl.push_back('{1, 1, 0, 8'h10, 32'h0,        1, 0, 8'h14, 32'h0,        0, 0, NA  });
    tbl.push_back('{0, 1, 0, 8'h10, 32'h0,        1, 0, 8'h14, 32'h0,        1, 0, 2'd1});
    tbl.push_back('{0, 1, 0, 8'h11, 32'h0,        1, 0, 8'h14, 32'h0,        1, 0, 2'd0});
    tbl.push_back('{0, 1, 0, 8'h12, 32'h0,        1, 0, 8'h14, 32'h0,        1, 0, NA  });
    tbl.push_back('{0, 1, 0, 8'h13, 32'h0,        1, 0, 8'h14, 32'h0,        1, 0, NA  });
    tbl.push_back('{0, 1, 0, 8'h18, 32'h0,        1, 0, 8'h14, 32'h0,        0, 1, 2'd0});
    tbl.push_back('{0, 1, 0, 8'h18, 32'h0,        1, 0, 8'h15, 32'h0,        0, 1, 2'd1});
    tbl.push_back('{0, 1, 0, 8'h18, 32'h0,        1, 0, 8'h16, 32'h0,        0, 1, NA  });
    tbl.push_back('{0, 1, 0, 8'h18, 32'h0,        1, 0, 8'h17, 32'h0,        0, 1, NA  });
    tbl.push_back('{0, 1, 0, 8'h18, 32'h0,        1, 0, 8'h19, 32'h0,        1, 0, 2'd1});
    tbl.push_back('{0, 0, 0, 8'h18, 32'h0,        1, 1, 8'h20, 32'h5A5A5A5A, 0, 1, 2'd0});
    tbl.push_back('{0, 1, 0, 8'h20, 32'h0,        0, 0, 8'h00, 32'h0,        1, 0, 2'd1});
    tbl.push_back('{0, 0, 0, 8'h00, 32'h0,        1, 0, 8'h21, 32'h0,        0, 1, 2'd0});
    tbl.push_back('{0, 0, 0, 8'h00, 32'h0,        1, 0, 8'h22, 32'h0,        0, 1, NA  });
    tbl.push_back('{0, 0, 1, 8'h33, 32'h1234,     0, 0, 8'h00, 32'h0,        0, 0, 2'd1});
    tbl.push_back('{0, 1, 0, 8'h23, 32'h0,        1, 0, 8'h24, 32'h0,        1, 0, 2'd1});
    tbl.push_back('{0, 1, 0, 8'h25, 32'h0,        1, 0, 8'h24, 32'h0,        1, 0, 2'd0});
    tbl.push_back('{0, 1, 0, 8'h26, 32'h0,        0, 0, 8'h24, 32'h0,        1, 0, NA  });
    tbl.push_back('{0, 1, 0, 8'h27, 32'h0,        0, 0, 8'h00, 32'h0,        1, 0, NA  });
    tbl.push_back('{0, 1, 1, 8'h30, 32'hCAFEF00D, 0, 0, 8'h00, 32'h0,        1, 0, NA  });
    tbl.push_back('{0, 1, 0, 8'h28, 32'h0,        1, 0, 8'h30, 32'h0,        0, 1, 2'd0});
    tbl.push_back('{0, 0, 0, 8'h00, 32'h0,        0, 0, 8'h00, 32'h0,        0, 0, 2'd1});
    tbl.push_back('{0, 1, 0, 8'h10, 32'h0,        0, 0, 8'h00, 32'h0,        1, 0, 2'd1});
    tbl.push_back('{1, 1, 0, 8'h11, 32'h0,        1, 0, 8'h12, 32'h0,        0, 0, NA  });
    tbl.push_back('{0, 1, 0, 8'h13, 32'h0,        1, 0, 8'h14, 32'h0,        1, 0, 2'd1});
    tbl.push_back('{0, 1, 0, 8'h15, 32'h0,        1, 0, 8'h14, 32'h0,        1, 0, 2'd0});
    tbl.push_back('{0, 0, 0, 8'h00, 32'h0,        0, 0, 8'h00, 32'h0,        0, 0, NA  });

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], 1'b1, i);

    // Sustained contention: runs must alternate and never exceed the burst allowance.
    v = '{0, 1, 0, 8'h40, 32'h0, 1, 0, 8'h41, 32'h0, 0, 0, NA};
    for (int i = 0; i < 24; i++) step(v, 1'b0, 100 + i);
    check("contention_gnt0_count", cnt_g0, 64'd12);
    check("contention_gnt1_count", cnt_g1, 64'd12);

    v = '{0, 0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0, 0, 0, NA};
    step(v, 1'b1, 200);
    check("scoreboard_drained", sb.size(), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
